dmem_responder: RTL and testbench

//  Data-memory responder for the pipelined RV32I core's load/store port: word-array storage behind a

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_lane_align.sv | 29 ++
 rtl/dmem_responder.sv | 93 +++++++++
 tb/tb_dmem_responder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM state type and funct3 validity check for the data-memory responder
package dmem_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} dmem_state_t;

   function automatic logic is_valid_f3(input logic [2:0] f3);
      return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
   endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-enable generation, store-data replication and load lane extract/extend
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wlanes,
   output logic [31:0] rdata,
   output logic        misalign
);
   logic        word, half;
   logic [1:0]  lo;
   logic [31:0] shifted;
   always_comb begin
      word     = funct3 == F3_W;
      half     = funct3[1:0] == F3_H[1:0];
      lo       = word ? 2'b00 : half ? {offset[1], 1'b0} : offset;
      misalign = word ? |offset : half & offset[0];
      be       = word ? 4'hf : half ? 4'b0011 << lo : 4'b0001 << lo;
      wlanes   = word ? wdata : half ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
      shifted  = rword >> {lo, 3'b000};
      rdata    = word ? rword
               : half ? {{16{!funct3[2] && shifted[15]}}, shifted[15:0]}
               : {{24{!funct3[2] && shifted[7]}}, shifted[7:0]};
   end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated valid/ready data memory for the RV32I load/store port
// DMEM_MISALIGN_TRAP_EN: misaligned H/W accesses fault instead of being force-aligned
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);
   localparam int IW = $clog2(DEPTH_WORDS);
`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   dmem_state_t state, state_nx;
   logic [31:0] mem [DEPTH_WORDS];
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q, wdata_q, wlanes, ld, rword;
   logic [3:0]  cnt, be;
   logic [IW-1:0] widx;
   logic        mis, err, fire;

   assign widx  = addr_q[IW+1:2];
   assign rword = mem[widx];
   assign fire  = state == ACCESS && cnt == 4'd0;
   assign err   = !is_valid_f3(f3_q) || (we_q && f3_q[2]) || addr_q[31:2] >= 30'(DEPTH_WORDS)
                || (TRAP && mis);

   dmem_lane_align u_align (
      .funct3   (f3_q),
      .offset   (addr_q[1:0]),
      .wdata    (wdata_q),
      .rword    (rword),
      .be       (be),
      .wlanes   (wlanes),
      .rdata    (ld),
      .misalign (mis)
   );

   always_ff @(posedge clk)
      state <= !rst ? IDLE : state_nx;

   always_comb begin
      state_nx  = state == IDLE   ? (req_valid ? ACCESS : IDLE)
                : state == ACCESS ? (cnt == 4'd0 ? RESP : ACCESS)
                : (rsp_ready ? IDLE : RESP);
      req_ready = state == IDLE;
      rsp_valid = state == RESP;
      busy      = state != IDLE;
   end

   always_ff @(posedge clk)
      if (!rst) begin
         cnt       <= 4'd0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         if (state == IDLE && req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= 4'(WAIT_CYCLES);
         end else if (state == ACCESS && cnt != 4'd0)
            cnt <= cnt - 4'd1;
         if (fire) begin
            rsp_rdata <= err || we_q ? 32'd0 : ld;
            rsp_err   <= err;
         end
      end

   // gated by rst so a reset landing on the commit cycle drops the store
   always_ff @(posedge clk)
      if (rst && fire && we_q && !err)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: byte-level reference model plus directed load/store vectors with literal expectations
module tb_dmem_responder;
   localparam int DEPTH = 1024;
   localparam int WAITC = 2;

   logic        clk = 0, rst = 0, req_valid = 0, req_we = 0, rsp_ready = 0;
   logic [2:0]  req_funct3 = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic        req_ready, rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int          checks = 0, errors = 0;
   logic [7:0]  mdl [DEPTH*4];
   logic        pend = 0, exp_err = 0;
   logic [31:0] exp_rd = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, want);
      end
   endtask

   // byte-addressed memory: size from funct3, misalignment handled per build option
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int n;
      logic [31:0] a;
      n  = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
      a  = addr;
      er = (addr >> 2) >= DEPTH || f3 == 3'd3 || f3 >= 3'd6 || (we && f3 >= 3'd4);
`ifdef DMEM_MISALIGN_TRAP_EN
      er = er || (a % n) != 0;
`else
      a = a - (a % n);
`endif
      rd = 0;
      if (!er) begin
         if (we) for (int i = 0; i < n; i++) mdl[a+i] = wd[8*i +: 8];
         else begin
            for (int i = 0; i < n; i++) rd = rd | (32'(mdl[a+i]) << (8*i));
            if (!f3[2] && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFFFFFF << (8*n));
         end
      end
   endfunction

   always @(negedge clk)
      if (rst && rsp_valid) begin
         chk("rsp_pending", 32'(pend), 32'd1);
         chk("rsp_rdata", rsp_rdata, exp_rd);
         chk("rsp_err", 32'(rsp_err), 32'(exp_err));
         chk("req_ready_in_resp", 32'(req_ready), 32'd0);
      end

   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int stall, input logic [31:0] lit_rd,
                       input logic lit_err, input string name);
      int lat;
      model(we, f3, addr, wd, exp_rd, exp_err);
      chk({name, "_req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 0; pend = 1;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, "_latency"}, 32'(lat), 32'(WAITC + 1));
      chk({name, "_rdata"}, rsp_rdata, lit_rd);
      chk({name, "_err"}, 32'(rsp_err), 32'(lit_err));
      repeat (stall) begin
         @(posedge clk); #1;
      end
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0; pend = 0;
      chk({name, "_valid_drop"}, 32'(rsp_valid), 32'd0);
      chk({name, "_ready_back"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      rst = 1;
      xact(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, "sw10");
      xact(0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0, "lw10");
      xact(1, 3'b000, 32'h13, 32'h80, 0, 32'h0, 0, "sb13");
      xact(0, 3'b000, 32'h13, 32'h0, 0, 32'hFFFFFF80, 0, "lb13");
      xact(0, 3'b100, 32'h13, 32'h0, 0, 32'h00000080, 0, "lbu13");
      xact(0, 3'b010, 32'h10, 32'h0, 0, 32'h80ADBEEF, 0, "lw10_after_sb");
      xact(0, 3'b010, 32'h10, 32'h0, 5, 32'h80ADBEEF, 0, "lw10_stall");
      xact(0, 3'b010, DEPTH*4, 32'h0, 0, 32'h0, 1, "lw_range");
      xact(0, 3'b011, 32'h10, 32'h0, 0, 32'h0, 1, "ld_f3_011");
      xact(1, 3'b100, 32'h10, 32'hFF, 0, 32'h0, 1, "sbu_err");
      xact(1, 3'b111, 32'h10, 32'hFF, 0, 32'h0, 1, "st_f3_111");
      xact(0, 3'b010, 32'h10, 32'h0, 0, 32'h80ADBEEF, 0, "lw10_after_err");
      xact(1, 3'b010, (DEPTH-1)*4, 32'hCAFEF00D, 0, 32'h0, 0, "sw_last");
      xact(0, 3'b010, (DEPTH-1)*4, 32'h0, 0, 32'hCAFEF00D, 0, "lw_last");
      xact(0, 3'b101, 32'h12, 32'h0, 0, 32'h000080AD, 0, "lhu12");
      xact(1, 3'b001, 32'h12, 32'h1234, 0, 32'h0, 0, "sh12");
      xact(0, 3'b010, 32'h10, 32'h0, 0, 32'h1234BEEF, 0, "lw10_after_sh");
      xact(1, 3'b010, 32'h20, 32'h11111111, 0, 32'h0, 0, "sw20");
`ifdef DMEM_MISALIGN_TRAP_EN
      xact(0, 3'b001, 32'h11, 32'h0, 0, 32'h0, 1, "lh11_mis");
      xact(1, 3'b010, 32'h21, 32'h55667788, 0, 32'h0, 1, "sw21_mis");
      xact(0, 3'b010, 32'h20, 32'h0, 0, 32'h11111111, 0, "lw20_after_mis");
`else
      xact(0, 3'b001, 32'h11, 32'h0, 0, 32'hFFFFBEEF, 0, "lh11_mis");
      xact(1, 3'b010, 32'h21, 32'h55667788, 0, 32'h0, 0, "sw21_mis");
      xact(0, 3'b010, 32'h20, 32'h0, 0, 32'h55667788, 0, "lw20_after_mis");
`endif
      // store aborted by reset while waiting in ACCESS; model left untouched
      req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      req_valid = 0;
      chk("abort_busy_access", 32'(busy), 32'd1);
      rst = 0;
      @(posedge clk); #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      chk("abort_rdata", rsp_rdata, 32'd0);
      rst = 1;
      @(posedge clk); #1;
`ifdef DMEM_MISALIGN_TRAP_EN
      xact(0, 3'b010, 32'h20, 32'h0, 0, 32'h11111111, 0, "lw20_after_abort");
`else
      xact(0, 3'b010, 32'h20, 32'h0, 0, 32'h55667788, 0, "lw20_after_abort");
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
